// File: rtl/song_reader.sv
// Song sequencer between song_rom and the note player: fetches each {note, duration}
// entry of the selected song, hands it over with a new_note pulse, waits for note_done.
module song_reader #(
    parameter int SONG_BITS = 2,
    parameter int NOTE_BITS = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic [SONG_BITS-1:0]           song,
    input  logic                           note_done,
    output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
    input  logic [11:0]                    rom_dout,
    output logic [5:0]                     note,
    output logic [5:0]                     duration,
    output logic                           new_note,
    output logic                           song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [NOTE_BITS-1:0] LAST_INDEX = '1;
    localparam logic [NOTE_BITS-1:0] INDEX_ONE  = NOTE_BITS'(1);

    state_t                 state_q, state_d;
    logic [NOTE_BITS-1:0]   index_q, index_d;
    logic [SONG_BITS-1:0]   song_q, song_d;
    logic [5:0]             note_q, note_d;
    logic [5:0]             duration_q, duration_d;
    logic                   new_note_q, new_note_d;
    logic                   song_done_q, song_done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            song_q      <= '0;
            note_q      <= '0;
            duration_q  <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            song_q      <= song_d;
            note_q      <= note_d;
            duration_q  <= duration_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        song_d      = song_q;
        note_d      = note_q;
        duration_d  = duration_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (play) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                // Zero-duration entries are silent rests and are skipped outright.
                if (rom_dout[5:0] == 6'd0) begin
                    state_d = S_NEXT;
                end else begin
                    note_d     = rom_dout[11:6];
                    duration_d = rom_dout[5:0];
                    new_note_d = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // new_note_q marks the first WAIT cycle; a note_done there is stale.
                if (note_done && !new_note_q) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (index_q == LAST_INDEX) begin
                    index_d     = '0;
                    song_done_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    index_d = index_q + INDEX_ONE;
                    state_d = play ? S_FETCH : S_IDLE;
                end
            end
            S_DONE: begin
                if (!play) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new song selection wins over everything and restarts from entry 0.
        if (song != song_q) begin
            song_d      = song;
            index_d     = '0;
            state_d     = S_IDLE;
            note_d      = note_q;
            duration_d  = duration_q;
            new_note_d  = 1'b0;
            song_done_d = 1'b0;
        end
    end

    assign rom_addr  = {song_q, index_q};
    assign note      = note_q;
    assign duration  = duration_q;
    assign new_note  = new_note_q;
    assign song_done = song_done_q;

endmodule
